regfile_bypass: RTL and testbench

- 8-entry x 16-bit register file for the processor decode stage.
- The write port is driven by writeback; two read ports are consumed by decode. It is the read-side consumer of the per-bit register storage.
- Adds same-cycle write-to-read bypass, so decode sees a value in the cycle it is being written.
- Raises err on malformed control inputs for the testbench error monitor.

---
 rtl/regfile_bypass_pkg.sv | 18 +
 rtl/regfile_bypass_if.sv | 27 ++
 rtl/regfile_bypass_nbitreg.sv | 33 +++
 rtl/regfile_bypass.sv | 69 ++++++
 tb/tb_regfile_bypass.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared register-file geometry for the decode and writeback stages,
// plus the simulation-only unknown-value detector used for the error flag.
package regfile_bypass_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_SELW  = 3;

    // True when any bit of v is X/Z; synthesis sees a constant 0.
    function automatic logic has_unknown(input logic [31:0] v);
`ifdef SYNTHESIS
        return 1'b0 & (^v);
`else
        return ((^v) === 1'bx);
`endif
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Decode/writeback bus into the register file: write port, two read ports
// and the sticky error flag.
interface regfile_bypass_if
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int SELW  = RF_SELW
);
    logic [SELW-1:0]  read1regsel;
    logic [SELW-1:0]  read2regsel;
    logic [SELW-1:0]  writeregsel;
    logic [WIDTH-1:0] writedata;
    logic             write;
    logic [WIDTH-1:0] read1data;
    logic [WIDTH-1:0] read2data;
    logic             err;

    modport master (
        output read1regsel, read2regsel, writeregsel, writedata, write,
        input  read1data, read2data, err
    );

    modport slave (
        input  read1regsel, read2regsel, writeregsel, writedata, write,
        output read1data, read2data, err
    );
endinterface

// File: rtl/regfile_bypass_nbitreg.sv
// WIDTH-bit storage register with write enable and asynchronous active-low
// clear; one instance per architectural register.
module nbitreg
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] writedata,
    input  logic             write,
    output logic [WIDTH-1:0] readdata
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (write) begin
            data_d = writedata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign readdata = data_q;
endmodule

// File: rtl/regfile_bypass.sv
// 8x16 register file with two combinational read ports, same-cycle
// write-to-read bypass, and a sticky flag for unknown control inputs.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    parameter int SELW  = RF_SELW
) (
    input  logic            clk,
    input  logic            rst,
    regfile_bypass_if.slave bus
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] wr_en;
    logic             err_q;
    logic             err_d;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_en[i] = bus.write && (bus.writeregsel == SELW'(i));
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        nbitreg #(.WIDTH(WIDTH)) u_reg (
            .clk       (clk),
            .rst       (rst),
            .writedata (bus.writedata),
            .write     (wr_en[g]),
            .readdata  (regs[g])
        );
    end

    // Bypass lets decode see writeback's value in the cycle it is written;
    // it is suppressed while reset is asserted so reads are clean zeros.
    always_comb begin
        bus.read1data = '0;
        bus.read2data = '0;
        if (rst) begin
            bus.read1data = (bus.write && (bus.writeregsel == bus.read1regsel))
                            ? bus.writedata : regs[bus.read1regsel];
            bus.read2data = (bus.write && (bus.writeregsel == bus.read2regsel))
                            ? bus.writedata : regs[bus.read2regsel];
        end
    end

    // Write select only matters when a write is actually requested.
    always_comb begin
        err_d = err_q;
        if (has_unknown(32'({bus.write, bus.read1regsel, bus.read2regsel}))) begin
            err_d = 1'b1;
        end
        if (bus.write && has_unknown(32'(bus.writeregsel))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_regfile_bypass;
    import regfile_bypass_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regfile_bypass_if #(.WIDTH(RF_WIDTH), .SELW(RF_SELW)) bus ();

    regfile_bypass #(.WIDTH(RF_WIDTH), .NREGS(RF_NREGS), .SELW(RF_SELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] r1;
        logic [15:0] r2;
        logic        e;
        bit          c1;
        bit          c2;
        bit          ce;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   checks = 0;
    int   errors = 0;
    bit   fourstate;
    logic probe;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mx = sb.pop_front();
            if (mx.c1) begin
                checks++;
                if (bus.read1data !== mx.r1) begin
                    errors++;
                    $display("FAIL %s read1data got %h expected %h", mx.name, bus.read1data, mx.r1);
                end
            end
            if (mx.c2) begin
                checks++;
                if (bus.read2data !== mx.r2) begin
                    errors++;
                    $display("FAIL %s read2data got %h expected %h", mx.name, bus.read2data, mx.r2);
                end
            end
            if (mx.ce) begin
                checks++;
                if (bus.err !== mx.e) begin
                    errors++;
                    $display("FAIL %s err got %b expected %b", mx.name, bus.err, mx.e);
                end
            end
        end
    end

    task automatic drive(input logic w, input logic [2:0] ws, input logic [15:0] wd,
                         input logic [2:0] s1, input logic [2:0] s2);
        bus.write       = w;
        bus.writeregsel = ws;
        bus.writedata   = wd;
        bus.read1regsel = s1;
        bus.read2regsel = s2;
    endtask

    task automatic push(input string n, input logic [15:0] r1, input logic [15:0] r2, input logic e);
        exp_t x;
        x.name = n; x.r1 = r1; x.r2 = r2; x.e = e;
        x.c1 = 1'b1; x.c2 = 1'b1; x.ce = 1'b1;
        sb.push_back(x);
    endtask

    task automatic push_err(input string n, input logic e);
        exp_t x;
        x.name = n; x.r1 = '0; x.r2 = '0; x.e = e;
        x.c1 = 1'b0; x.c2 = 1'b0; x.ce = 1'b1;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        probe = 1'bx;
        fourstate = (probe === 1'bx);

        // Reset asserted: bypass disabled even with a matching write.
        drive(1'b1, 3'd2, 16'h9999, 3'd2, 3'd2);
        #1;
        push("rst_bypass_off", 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
            push("t1_reset_read", 16'h0000, 16'h0000, 1'b0);
            step();
        end

        drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4);
        push("t2_write_bypass", 16'hBEEF, 16'h0000, 1'b0);
        step();
        drive(1'b0, 3'd3, 16'hBEEF, 3'd3, 3'd3);
        push("t2_read_back", 16'hBEEF, 16'hBEEF, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd3);
        push("t2_reg4_zero", 16'h0000, 16'hBEEF, 1'b0);
        step();

        drive(1'b1, 3'd2, 16'h2222, 3'd0, 3'd0);
        push("t3_setup", 16'h0000, 16'h0000, 1'b0);
        step();
        drive(1'b1, 3'd5, 16'h1234, 3'd5, 3'd2);
        push("t3_bypass", 16'h1234, 16'h2222, 1'b0);
        step();
        drive(1'b0, 3'd5, 16'h0000, 3'd5, 3'd2);
        push("t3_hold", 16'h1234, 16'h2222, 1'b0);
        step();

        drive(1'b1, 3'd2, 16'hABCD, 3'd2, 3'd2);
        push("dual_bypass", 16'hABCD, 16'hABCD, 1'b0);
        step();
        drive(1'b1, 3'd2, 16'h5555, 3'd2, 3'd3);
        push("b2b_second", 16'h5555, 16'hBEEF, 1'b0);
        step();
        drive(1'b1, 3'd0, 16'h0F0F, 3'd2, 3'd0);
        push("b2b_last_wins", 16'h5555, 16'h0F0F, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd2);
        push("reg0_writable", 16'h0F0F, 16'h5555, 1'b0);
        step();

        drive(1'b0, 3'd6, 16'hFFFF, 3'd6, 3'd6);
        push("t4_no_bypass", 16'h0000, 16'h0000, 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 3'd6, 3'd6);
        push("t4_no_store", 16'h0000, 16'h0000, 1'b0);
        step();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'hA5A0 + 16'(i), 3'(i), 3'(i));
            push("t5_fill", 16'hA5A0 + 16'(i), 16'hA5A0 + 16'(i), 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'((i + 1) % 8));
            push("t5_readback", 16'hA5A0 + 16'(i), 16'hA5A0 + 16'((i + 1) % 8), 1'b0);
            step();
        end

        // Reset pulse lands between edges; outputs must clear before any clock.
        drive(1'b0, 3'd0, 16'h0000, 3'd1, 3'd7);
        #1;
        rst = 1'b0;
        drive(1'b1, 3'd1, 16'hDEAD, 3'd1, 3'd7);
        push("t5_async_clear", 16'h0000, 16'h0000, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 3'd1, 3'd7);
        push("t5_write_ignored", 16'h0000, 16'h0000, 1'b0);
        step();

        drive(1'b1, 3'bxx1, 16'h7777, 3'd0, 3'd0);
        push_err("t6_before_edge", 1'b0);
        step();
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        push_err("t6_err_set", fourstate);
        step();
        push_err("t6_err_sticky", fourstate);
        step();
        #1;
        rst = 1'b0;
        push("t6_rst_clears", 16'h0000, 16'h0000, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 3'd1, 3'd3);
        push("t6_after_rst", 16'h0000, 16'h0000, 1'b0);
        step();

        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard pending %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
